// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter (inhibit, request, 11-bit
//            frame clocked by the device, acknowledge sample, timeout)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_err
);

    localparam int              C_MAX      = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                                             TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int              C_CW       = $clog2(C_MAX + 1);
    localparam logic [C_CW-1:0] C_INH_LAST = C_CW'(INHIBIT_CYCLES - 1);
    localparam logic [C_CW-1:0] C_TMO_LAST = C_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [C_CW-1:0] C_ONE      = C_CW'(1);
    localparam logic [5:0]      C_FALL     = 6'b111000;
    localparam logic [3:0]      C_IDX_PAR  = 4'd9;
    localparam logic [3:0]      C_IDX_STOP = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SEND    = 3'd3,
        S_ACK     = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic [5:0]      hist_q;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic            err_q, err_d;
    logic            w_fall;
    logic [10:0]     w_frame;

    // A falling edge only counts after three settled highs then three settled lows.
    assign w_fall  = (hist_q == C_FALL);
    assign w_frame = {1'b1, par_q, byte_q, 1'b0};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q  <= 2'b00;
            data_sync_q <= 2'b00;
            hist_q      <= 6'b000000;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], i_ps2_clk};
            data_sync_q <= {data_sync_q[0], i_ps2_data};
            hist_q      <= {hist_q[4:0], clk_sync_q[1]};
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            byte_q  <= 8'h00;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        byte_d        = byte_q;
        par_d         = par_q;
        err_d         = err_q;
        o_ps2_clk_oe  = 1'b0;
        o_ps2_data_oe = 1'b0;
        o_ready       = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    byte_d  = i_data;
                    par_d   = ~^i_data;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                o_ps2_clk_oe = 1'b1;
                if (cnt_q == C_INH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_REQ: begin
                o_ps2_clk_oe  = 1'b1;
                o_ps2_data_oe = 1'b1;
                cnt_d         = '0;
                idx_d         = 4'd0;
                state_d       = S_SEND;
            end
            S_SEND: begin
                o_ps2_data_oe = ~w_frame[idx_q];
                cnt_d         = cnt_q + C_ONE;
                if (cnt_q >= C_TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (w_fall) begin
                    if (idx_q == C_IDX_PAR) begin
                        idx_d   = C_IDX_STOP;
                        state_d = S_ACK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                // Stop bit: line released; the ack edge takes priority over timeout.
                cnt_d = cnt_q + C_ONE;
                if (w_fall) begin
                    err_d   = data_sync_q[1];
                    state_d = S_FIN;
                end else if (cnt_q >= C_TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                o_done  = 1'b1;
                o_err   = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles from clock release to acknowledge (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  request to send i_data; accepted only when o_ready=1.
REQ-006 SHALL have port i_data  input  8  command byte, sampled on the accepting cycle.
REQ-007 SHALL have port i_ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-008 SHALL have port i_ps2_data  input  1  raw PS/2 data line, asynchronous.
REQ-009 SHALL have port o_ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-010 SHALL have port o_ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-011 SHALL have port o_ready  output  1  1 in IDLE only.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse at end of every accepted transfer.
REQ-013 SHALL have port o_err  output  1  qualified by o_done: 1 = no acknowledge or timeout.

Function
REQ-014 SHALL pass i_ps2_clk and i_ps2_data through 2-FF synchronizers before use.
REQ-015 SHALL shift synchronized clock into a 6-bit history each cycle; falling edge = history 6'b111000 (glitch filter).
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, FIN.
REQ-017 IDLE: both oe=0; i_start=1 latches i_data, computes odd parity (~^i_data), clears counters, goes to INHIBIT next cycle.
REQ-018 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: clk_oe=1, data_oe=1 for exactly 1 cycle, then SEND.
REQ-020 SEND: clk_oe=0; bit index 0..10 starts at 0 with data_oe=1 (start bit 0).
REQ-021 On each detected falling edge in SEND, index increments and data_oe becomes ~bit: indices 1-8 = i_data[0..7] LSB first, 9 = parity, 10 = stop (data_oe=0).
REQ-022 On the falling edge with index=10, SHALL sample synchronized data: 0 = ack OK, 1 = error; go to FIN.
REQ-023 Timeout counter SHALL clear on entry to SEND and increment each cycle; reaching TIMEOUT_CYCLES before ack SHALL release both lines and go to FIN with error.
REQ-024 FIN: o_done=1, o_err per outcome, both oe=0, for exactly 1 cycle, then IDLE.
REQ-025 i_start while o_ready=0 SHALL be ignored, with no queueing.
REQ-026 Falling edges in IDLE, INHIBIT or REQ SHALL be ignored.
REQ-027 When timeout and the 11th edge coincide in the same cycle, the ack sample SHALL win.

Reset
REQ-028 i_rst_n=0 SHALL immediately force state IDLE, o_ps2_clk_oe=0, o_ps2_data_oe=0, o_done=0, o_err=0, counters/synchronizers/history cleared to 0 (history set so no false edge), o_ready=1 after release.
REQ-029 Reset mid-transfer SHALL abandon the transfer silently with no o_done pulse.

Verification (bench parameters INHIBIT_CYCLES=20, TIMEOUT_CYCLES=3000; device model clock period 100 clk)
REQ-030 Send 0xED, device acks with data=0 -> clk_oe high 20 cycles, both oe high 1 cycle; data line sequence 0,1,0,1,1,0,1,1,1,1(parity),1(stop); o_done=1, o_err=0.
REQ-031 Send 0x00, device leaves data high at ack -> parity bit 1; o_done=1, o_err=1.
REQ-032 Send 0xF4, device never clocks -> both oe=0 and o_done=1, o_err=1 exactly 3000 cycles after SEND entry.
REQ-033 Inject 2-cycle low glitches on ps2_clk during SEND -> no index advance; 0xAA transfer completes with o_err=0.
REQ-034 Assert i_rst_n=0 at index 5 -> both oe=0 in the same cycle, no o_done; next i_start of 0xFF completes normally.
REQ-035 Pulse i_start during SEND with a different byte -> ignored; the original byte is transmitted unchanged.
